// File: rtl/shr_serial_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : shr_serial_loader_if
// Description : Bundles the frame-request inputs and serial/status outputs of
//               shr_serial_loader.
//               slave  - the loader: sees trig/clr_mode/clr_2_one/data_reg,
//                        drives clk/din/syn/out_en/clk_out_en/busy/done/
//                        frames_sent.
//               master - the requester side (JTAG blocks / testbench).
// Revision    : 1.0 - initial multi-lane release
// ============================================================================
interface shr_serial_loader_if #(
    parameter int LANES      = 1,
    parameter int FRAME_BITS = 644
);
    logic                          trig;
    logic                          clr_mode;
    logic                          clr_2_one;
    logic [LANES*FRAME_BITS-1:0]   data_reg;
    logic                          clk;
    logic [LANES-1:0]              din;
    logic                          syn;
    logic                          out_en;
    logic                          clk_out_en;
    logic                          busy;
    logic                          done;
    logic [15:0]                   frames_sent;

    modport slave (
        input  trig, clr_mode, clr_2_one, data_reg,
        output clk, din, syn, out_en, clk_out_en, busy, done, frames_sent
    );

    modport master (
        output trig, clr_mode, clr_2_one, data_reg,
        input  clk, din, syn, out_en, clk_out_en, busy, done, frames_sent
    );
endinterface
`default_nettype wire

// File: rtl/shr_serial_loader.sv
`default_nettype none
// ============================================================================
// Module      : shr_serial_loader
// Description : Multi-lane serial shift-register loader. A rising edge on the
//               asynchronous trig level launches one frame: the captured
//               pattern (data_reg or a constant clear pattern) is shifted out
//               on LANES din pins sharing one serial clock and one active-low
//               frame sync, with SYN_LEAD serial periods of sync guard before
//               and after the data bits.
// Ports       : clk_in, rst_n (async, active low) - block clock / reset
//               bus (slave) - trig, clr_mode, clr_2_one, data_reg in;
//                             clk, din, syn, out_en, clk_out_en, busy, done,
//                             frames_sent out (all registered)
// Revision    : 1.0 - initial multi-lane release
// ============================================================================
module shr_serial_loader #(
    parameter int FRAME_BITS = 644,
    parameter int LANES      = 1,
    parameter int DIV        = 4,
    parameter int SYN_LEAD   = 1,
    parameter int MSB_FIRST  = 1
) (
    input  wire logic            clk_in,
    input  wire logic            rst_n,
    shr_serial_loader_if.slave   bus
);
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    // Half-period counter covers both the guard phases and the data phase.
    localparam int HMAX = 2 * ((FRAME_BITS > SYN_LEAD) ? FRAME_BITS : SYN_LEAD);
    localparam int HW   = $clog2(HMAX);

    localparam logic [CW-1:0] C_CNT_LAST   = CW'(DIV - 1);
    localparam logic [HW-1:0] C_SHIFT_LAST = HW'(2 * FRAME_BITS - 1);
    localparam logic [HW-1:0] C_LEAD_LAST  = HW'((SYN_LEAD > 0) ? 2 * SYN_LEAD - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_SHIFT = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                              state_q, state_d;
    logic                                trig_s1_q, trig_s2_q, trig_prev_q;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic [HW-1:0]                       half_q, half_d;
    logic [LANES-1:0][FRAME_BITS-1:0]    pat_q, pat_d;
    logic                                clk_q, clk_d;
    logic [LANES-1:0]                    din_q, din_d;
    logic                                syn_q, syn_d;
    logic                                out_en_q, out_en_d;
    logic                                clk_out_en_q, clk_out_en_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic [15:0]                         frames_q, frames_d;

    logic trig_rise;
    logic tick;
    logic framing;

    assign trig_rise = trig_s2_q & ~trig_prev_q;
    assign tick      = (cnt_q == C_CNT_LAST);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            trig_s1_q    <= 1'b0;
            trig_s2_q    <= 1'b0;
            trig_prev_q  <= 1'b0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            half_q       <= '0;
            pat_q        <= '0;
            clk_q        <= 1'b0;
            din_q        <= '0;
            syn_q        <= 1'b1;
            out_en_q     <= 1'b0;
            clk_out_en_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            frames_q     <= '0;
        end else begin
            trig_s1_q    <= bus.trig;
            trig_s2_q    <= trig_s1_q;
            // Edge register tracks the level in every state, so an edge seen
            // while busy is consumed rather than replayed later.
            trig_prev_q  <= trig_s2_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            half_q       <= half_d;
            pat_q        <= pat_d;
            clk_q        <= clk_d;
            din_q        <= din_d;
            syn_q        <= syn_d;
            out_en_q     <= out_en_d;
            clk_out_en_q <= clk_out_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            frames_q     <= frames_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        pat_d   = pat_q;

        case (state_q)
            S_IDLE: begin
                if (trig_rise) begin
                    for (int k = 0; k < LANES; k++) begin
                        pat_d[k] = bus.clr_mode ? {FRAME_BITS{bus.clr_2_one}}
                                                : bus.data_reg[k*FRAME_BITS +: FRAME_BITS];
                    end
                    state_d = (SYN_LEAD == 0) ? S_SHIFT : S_PRE;
                    cnt_d   = '0;
                    half_d  = '0;
                end
            end
            S_PRE, S_POST: begin
                cnt_d = tick ? '0 : cnt_q + CW'(1);
                if (tick) begin
                    if (half_q == C_LEAD_LAST) begin
                        half_d  = '0;
                        state_d = (state_q == S_PRE) ? S_SHIFT : S_DONE;
                    end else begin
                        half_d  = half_q + HW'(1);
                    end
                end
            end
            S_SHIFT: begin
                // Even half-periods are the low phase, odd the high phase.
                cnt_d = tick ? '0 : cnt_q + CW'(1);
                if (tick) begin
                    if (half_q == C_SHIFT_LAST) begin
                        half_d  = '0;
                        state_d = (SYN_LEAD == 0) ? S_DONE : S_POST;
                    end else begin
                        half_d = half_q + HW'(1);
                        // Advance the pattern only after a high phase so din
                        // changes at the start of the next low phase.
                        if (half_q[0]) begin
                            for (int k = 0; k < LANES; k++) begin
                                if (MSB_FIRST != 0)
                                    pat_d[k] = {pat_q[k][FRAME_BITS-2:0], 1'b0};
                                else
                                    pat_d[k] = {1'b0, pat_q[k][FRAME_BITS-1:1]};
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                half_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                half_d  = '0;
            end
        endcase
    end

    // Outputs are decoded from next-state values and registered, so they
    // change on the same edge as the state they describe.
    always_comb begin
        framing      = (state_d == S_PRE) || (state_d == S_SHIFT) || (state_d == S_POST);
        clk_d        = (state_d == S_SHIFT) && half_d[0];
        syn_d        = ~framing;
        out_en_d     = framing;
        clk_out_en_d = (state_d == S_SHIFT);
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        frames_d     = frames_q + ((state_d == S_DONE) ? 16'd1 : 16'd0);
        din_d        = '0;
        for (int k = 0; k < LANES; k++) begin
            if (framing)
                din_d[k] = (MSB_FIRST != 0) ? pat_d[k][FRAME_BITS-1] : pat_d[k][0];
        end
    end

    assign bus.clk         = clk_q;
    assign bus.din         = din_q;
    assign bus.syn         = syn_q;
    assign bus.out_en      = out_en_q;
    assign bus.clk_out_en  = clk_out_en_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.frames_sent = frames_q;

endmodule
`default_nettype wire

// File: doc/shr_serial_loader.md
Name: shr_serial_loader

Overview:
Parametrised multi-lane serial shift-register loader, the next generation of the single-lane JTAG-triggered DIN/CLK/SYNC driver. A trigger in the JTAG domain launches one frame: a snapshot of the parallel data register, or a constant clear pattern, is shifted out on LANES data pins that share one serial clock and one frame sync. The block sits between the vJTAG data/key blocks and the GPIO header. It adds a configurable serial-clock divider, sync lead/lag guard times, selectable bit order, and busy/done/frame-count status.

Parameters:
FRAME_BITS, 644, bits per lane per frame (>=2)
LANES, 1, number of parallel din lanes (>=1)
DIV, 4, clk_in cycles per serial-clock half period (>=1)
SYN_LEAD, 1, serial-clock periods of syn-asserted guard before and after the data bits (>=0)
MSB_FIRST, 1, 1 = bit FRAME_BITS-1 shifted first; 0 = bit 0 first

Ports:
clk_in  in  1  block clock (PLL output)
rst_n  in  1  asynchronous active-low reset
trig  in  1  frame request, level from JTAG (tck) domain, asynchronous to clk_in
clr_mode  in  1  1 = send constant clear pattern instead of data_reg
clr_2_one  in  1  clear pattern value (1 = all ones, 0 = all zeros)
data_reg  in  LANES*FRAME_BITS  lane k = data_reg[k*FRAME_BITS +: FRAME_BITS]
clk  out  1  serial clock to shift registers
din  out  LANES  serial data per lane
syn  out  1  frame sync, active-low (idles high)
out_en  out  1  high while a frame is in progress (syn low)
clk_out_en  out  1  high only while data bits are clocked
busy  out  1  high from frame accept until DONE exits
done  out  1  one-cycle pulse at frame end
frames_sent  out  16  completed-frame counter, wraps

Behaviour:
- Reset (async, rst_n=0): state IDLE, clk=0, din=0, syn=1, out_en=0, clk_out_en=0, busy=0, done=0, frames_sent=0, sync flops cleared. Reset mid-frame aborts immediately; the frame is not counted.
- trig passes a 2-flop synchroniser plus one edge register. A rising edge is accepted only in IDLE. Edges during busy are dropped, not queued.
- Accept cycle: capture the shift pattern per lane, either data_reg or, if clr_mode=1, FRAME_BITS copies of clr_2_one (clr inputs are sampled here only). Then enter PRE; busy=1.
- Tick divider: counter 0..DIV-1, reset to 0 on every state entry. A tick occurs when the counter reaches DIV-1. One serial period equals 2*DIV clk_in cycles.
- PRE: syn=0, out_en=1, clk=0, din=first bit. Lasts SYN_LEAD*2*DIV cycles; if SYN_LEAD=0, go directly to SHIFT.
- SHIFT: clk_out_en=1. Each bit has a low phase of DIV cycles with clk=0, then a high phase of DIV cycles with clk=1. din updates only at the start of a low phase, so it is stable at every clk rising edge. Bit index counts 0..FRAME_BITS-1. After the last high phase, clk returns to 0 and the block enters POST.
- POST: syn=0, clk=0, din holds the last bit. Lasts SYN_LEAD*2*DIV cycles.
- DONE: one cycle. syn=1, out_en=0, din=0, done=1, frames_sent+=1 (0xFFFF→0x0000). Then IDLE with busy=0.
- Frame length from the first PRE cycle through the DONE cycle: (2*SYN_LEAD+FRAME_BITS)*2*DIV+1 cycles.
- data_reg and clr inputs may change freely while busy; the frame uses the captured pattern only.
- Bit order is set by MSB_FIRST and applies identically to all lanes.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. FRAME_BITS=8, LANES=2, DIV=2, SYN_LEAD=1, lane0=8'hA5, lane1=8'h3C, pulse trig -> syn low for 40 cycles then DONE. din[0] at clk rises = 1,0,1,0,0,1,0,1 and din[1] = 0,0,1,1,1,1,0,0. Exactly 8 clk rises, done pulses once, frames_sent=1.
2. clr_mode=1, clr_2_one=1 with data_reg=0 -> both lanes shift 8 ones. Repeat with clr_2_one=0 and data_reg=all ones -> 8 zeros.
3. Second trig edge while busy, plus data_reg changed mid-frame -> frame bits unchanged, only one frame sent, frames_sent=1.
4. rst_n low during SHIFT bit 4 -> clk=0, syn=1, busy=0 immediately. frames_sent unchanged. Next trig sends a complete correct frame.
5. MSB_FIRST=0, lane0=8'h01 -> first sampled bit 1, remaining seven 0. With MSB_FIRST=1 the 1 is sampled last.
6. DIV=1, SYN_LEAD=0 -> clk toggles every cycle, syn low for exactly 16 cycles. Separately, preload frames_sent near 0xFFFF via frames -> the counter wraps to 0x0000.
